// File: rtl/decode_stage.sv
// Decode stage: one instruction per cycle into a registered issue bundle, with an
// NREG x DW register file, a pending-write scoreboard and writeback bypass.
module decode_stage #(
   parameter int DW   = 4,
   parameter int NREG = 2,
   parameter int RW   = $clog2(NREG),
   parameter int IW   = 4 + 2*RW + DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] inst,
   input  logic          wb_en,
   input  logic [RW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] op_a,
   output logic [DW-1:0] op_b,
   output logic          is_imm,
   output logic          is_jump,
   output logic          is_jnc,
   output logic          mem_w,
   output logic [RW-1:0] s_reg,
   output logic          out_en,
   output logic          illegal
);

   logic [DW-1:0]   regs [NREG];
   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_next;

   logic [3:0]    op;
   logic [RW-1:0] rd;
   logic [RW-1:0] rs;
   logic [DW-1:0] imm;

   assign op  = inst[IW-1 -: 4];
   assign rd  = inst[DW+2*RW-1 -: RW];
   assign rs  = inst[DW+RW-1 -: RW];
   assign imm = inst[DW-1:0];

   logic [DW-1:0] rd_val;
   logic [DW-1:0] rs_val;

   assign rd_val = (wb_en && wb_addr == rd) ? wb_data : regs[rd];
   assign rs_val = (wb_en && wb_addr == rs) ? wb_data : regs[rs];

   logic          uses_rd;
   logic          uses_rs;
   logic [DW-1:0] d_a;
   logic [DW-1:0] d_b;
   logic          d_imm;
   logic          d_jump;
   logic          d_jnc;
   logic          d_memw;
   logic          d_out;
   logic          d_ill;
   logic [RW-1:0] d_sreg;

   always_comb begin
      uses_rd = 1'b0;
      uses_rs = 1'b0;
      d_a     = '0;
      d_b     = '0;
      d_imm   = 1'b0;
      d_jump  = 1'b0;
      d_jnc   = 1'b0;
      d_memw  = 1'b0;
      d_out   = 1'b0;
      d_ill   = 1'b0;
      case (op)
         4'b0000: begin uses_rd = 1'b1; d_a = rd_val; d_b = imm; d_imm = 1'b1; d_memw = 1'b1; end
         4'b0101: begin uses_rd = 1'b1; uses_rs = 1'b1; d_a = rd_val; d_b = rs_val; d_memw = 1'b1; end
         4'b0011: begin d_b = imm; d_imm = 1'b1; d_memw = 1'b1; end
         4'b0001: begin uses_rs = 1'b1; d_a = rs_val; d_memw = 1'b1; end
         4'b0010: d_memw = 1'b1;
         4'b1001: begin uses_rs = 1'b1; d_a = rs_val; d_out = 1'b1; end
         4'b1011: begin d_b = imm; d_imm = 1'b1; d_out = 1'b1; end
         4'b1111: begin d_b = imm; d_imm = 1'b1; d_jump = 1'b1; end
         4'b1110: begin d_b = imm; d_imm = 1'b1; d_jump = 1'b1; d_jnc = 1'b1; end
         4'b1000: ;
         default: d_ill = 1'b1;
      endcase
   end

   // s_reg is only meaningful when the result is written back; zero otherwise
   assign d_sreg = d_memw ? rd : '0;

   logic busy_rd;
   logic busy_rs;
   logic hazard;
   logic accept;
   logic cancel;

   assign busy_rd  = pend[rd] && !(wb_en && wb_addr == rd);
   assign busy_rs  = pend[rs] && !(wb_en && wb_addr == rs);
   assign hazard   = (uses_rd && busy_rd) || (uses_rs && busy_rs);
   assign in_ready = rst && !flush && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   // an entry EX takes in the flush cycle is committed and still owes a writeback
   assign cancel   = flush && out_valid && !out_ready;

   always_comb begin
      pend_next = pend;
      if (wb_en)
         pend_next[wb_addr] = 1'b0;
      if (cancel && mem_w)
         pend_next[s_reg] = 1'b0;
      if (accept && d_memw)
         pend_next[rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pend      <= '0;
         out_valid <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         is_imm    <= 1'b0;
         is_jump   <= 1'b0;
         is_jnc    <= 1'b0;
         mem_w     <= 1'b0;
         s_reg     <= '0;
         out_en    <= 1'b0;
         illegal   <= 1'b0;
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else begin
         pend <= pend_next;
         if (wb_en)
            regs[wb_addr] <= wb_data;
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
            op_a      <= d_a;
            op_b      <= d_b;
            is_imm    <= d_imm;
            is_jump   <= d_jump;
            is_jnc    <= d_jnc;
            mem_w     <= d_memw;
            s_reg     <= d_sreg;
            out_en    <= d_out;
            illegal   <= d_ill;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic, all checked
// against an instruction-level model of the register file, scoreboard and issue slot.
module tb_decode_stage;

   localparam int DW   = 4;
   localparam int NREG = 2;
   localparam int RW   = 1;
   localparam int IW   = 4 + 2*RW + DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] inst;
   logic          wb_en;
   logic [RW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic          is_imm;
   logic          is_jump;
   logic          is_jnc;
   logic          mem_w;
   logic [RW-1:0] s_reg;
   logic          out_en;
   logic          illegal;

   decode_stage #(.DW(DW), .NREG(NREG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
      .is_imm(is_imm), .is_jump(is_jump), .is_jnc(is_jnc), .mem_w(mem_w),
      .s_reg(s_reg), .out_en(out_en), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      bit            imm;
      bit            jump;
      bit            jnc;
      bit            memw;
      logic [RW-1:0] sreg;
      bit            outen;
      bit            ill;
   } bundle_t;

   typedef struct {
      logic [RW-1:0] addr;
      logic [DW-1:0] data;
   } wb_t;

   localparam int K_ADDI = 0, K_ADD = 1, K_MOVI = 2, K_MOV = 3, K_IN = 4, K_OUT = 5;
   localparam int K_OUTI = 6, K_JMP = 7, K_JNC = 8, K_NOP = 9, K_ILL = 10;

   logic [DW-1:0]   m_regs [NREG];
   logic [NREG-1:0] m_pend;
   bit              m_valid;
   bundle_t         m_b;
   bit              last_ready;
   wb_t             wbq [$];

   function automatic logic [DW-1:0] mread(input logic [RW-1:0] idx);
      return (wb_en && wb_addr == idx) ? wb_data : m_regs[idx];
   endfunction

   function automatic logic [IW-1:0] mk(input logic [3:0] o, input logic [RW-1:0] d,
                                        input logic [RW-1:0] s, input logic [DW-1:0] i);
      return {o, d, s, i};
   endfunction

   // Instruction semantics as property sets over mnemonics
   task automatic mdecode(input logic [IW-1:0] w, output bundle_t b,
                          output bit reads_rd, output bit reads_rs);
      int kind;
      bit writes, imm_b;
      logic [RW-1:0] d, s;
      logic [DW-1:0] i;
      d = w[DW+2*RW-1 -: RW];
      s = w[DW+RW-1 -: RW];
      i = w[DW-1:0];
      case (w[IW-1 -: 4])
         4'h0: kind = K_ADDI;  4'h5: kind = K_ADD;  4'h3: kind = K_MOVI;
         4'h1: kind = K_MOV;   4'h2: kind = K_IN;   4'h9: kind = K_OUT;
         4'hB: kind = K_OUTI;  4'hF: kind = K_JMP;  4'hE: kind = K_JNC;
         4'h8: kind = K_NOP;   default: kind = K_ILL;
      endcase
      writes   = kind == K_ADDI || kind == K_ADD || kind == K_MOVI || kind == K_MOV || kind == K_IN;
      reads_rd = kind == K_ADDI || kind == K_ADD;
      reads_rs = kind == K_ADD || kind == K_MOV || kind == K_OUT;
      imm_b    = kind == K_ADDI || kind == K_MOVI || kind == K_OUTI || kind == K_JMP || kind == K_JNC;
      b.a      = reads_rd ? mread(d) : (reads_rs ? mread(s) : '0);
      b.b      = imm_b ? i : ((kind == K_ADD) ? mread(s) : '0);
      b.imm    = imm_b;
      b.jump   = kind == K_JMP || kind == K_JNC;
      b.jnc    = kind == K_JNC;
      b.memw   = writes;
      b.sreg   = writes ? d : '0;
      b.outen  = kind == K_OUT || kind == K_OUTI;
      b.ill    = kind == K_ILL;
   endtask

   task automatic step();
      bundle_t d;
      bit rrd, rrs, hz, exp_ready, acc, iss, cancel;
      logic [RW-1:0] rd, rs;
      wb_t w;
      #2;
      rd = inst[DW+2*RW-1 -: RW];
      rs = inst[DW+RW-1 -: RW];
      mdecode(inst, d, rrd, rrs);
      hz = (rrd && m_pend[rd] && !(wb_en && wb_addr == rd)) ||
           (rrs && m_pend[rs] && !(wb_en && wb_addr == rs));
      exp_ready = rst && !flush && !hz && (!m_valid || out_ready);
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      last_ready = in_ready;
      if (!rst) begin
         for (int i = 0; i < NREG; i++) m_regs[i] = '0;
         m_pend  = '0;
         m_valid = 0;
         m_b     = '{default: 0};
         wbq.delete();
      end else begin
         acc    = in_valid && exp_ready;
         iss    = m_valid && out_ready;
         cancel = flush && m_valid && !out_ready;
         if (iss && m_b.memw) begin
            w.addr = m_b.sreg;
            w.data = DW'($urandom);
            wbq.push_back(w);
         end
         if (wb_en) m_pend[wb_addr] = 1'b0;
         if (cancel && m_b.memw) m_pend[m_b.sreg] = 1'b0;
         if (acc && d.memw) m_pend[rd] = 1'b1;
         if (wb_en) m_regs[wb_addr] = wb_data;
         if (flush) m_valid = 0;
         else if (acc) begin m_valid = 1; m_b = d; end
         else if (iss) m_valid = 0;
      end
      @(posedge clk);
      #1;
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         check("op_a", 32'(op_a), 32'(m_b.a));
         check("op_b", 32'(op_b), 32'(m_b.b));
         check("is_imm", 32'(is_imm), 32'(m_b.imm));
         check("is_jump", 32'(is_jump), 32'(m_b.jump));
         check("is_jnc", 32'(is_jnc), 32'(m_b.jnc));
         check("mem_w", 32'(mem_w), 32'(m_b.memw));
         check("s_reg", 32'(s_reg), 32'(m_b.sreg));
         check("out_en", 32'(out_en), 32'(m_b.outen));
         check("illegal", 32'(illegal), 32'(m_b.ill));
      end
   endtask

   task automatic idle();
      in_valid = 0; inst = '0; wb_en = 0; wb_addr = '0; wb_data = '0;
      flush = 0; out_ready = 1;
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      step();
      rst = 1;
   endtask

   initial begin
      wb_t w;
      idle();

      // reset held two cycles
      rst = 0;
      step();
      step();
      check("rst_bundle", 32'({out_valid, op_a, op_b, is_imm, is_jump, is_jnc, mem_w,
                               s_reg, out_en, illegal}), 32'd0);
      rst = 1;
      step();
      check("rst_ready", 32'(last_ready), 32'd1);
      in_valid = 1; inst = mk(4'h1, 1, 0, 0);
      step();
      check("rst_rega", 32'(op_a), 32'd0);

      // RAW stall then bypass release
      do_reset();
      in_valid = 1; inst = mk(4'h3, 0, 0, 4'd5);
      step();
      inst = mk(4'h5, 1, 0, 0);
      step();
      check("raw_stall0", 32'(last_ready), 32'd0);
      step();
      check("raw_stall1", 32'(last_ready), 32'd0);
      wb_en = 1; wb_addr = 0; wb_data = 4'd5;
      step();
      check("raw_release", 32'(last_ready), 32'd1);
      check("raw_bypass", 32'(op_b), 32'd5);
      idle();

      // backpressure holds the bundle
      do_reset();
      out_ready = 0; in_valid = 1; inst = mk(4'h3, 1, 0, 4'd9);
      step();
      inst = mk(4'h3, 0, 0, 4'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_ready", 32'(last_ready), 32'd0);
         check("hold_opb", 32'(op_b), 32'd9);
         check("hold_sreg", 32'(s_reg), 32'd1);
      end
      out_ready = 1;
      step();
      check("hold_next", 32'(op_b), 32'd1);
      idle();

      // flush of a stalled ADDI frees its destination
      do_reset();
      out_ready = 0; in_valid = 1; inst = mk(4'h0, 0, 0, 4'd3);
      step();
      in_valid = 0; flush = 1;
      step();
      check("flush_valid", 32'(out_valid), 32'd0);
      flush = 0; in_valid = 1; inst = mk(4'h1, 1, 0, 0);
      step();
      check("flush_noStall", 32'(last_ready), 32'd1);
      idle();

      // undefined opcode
      do_reset();
      in_valid = 1; inst = mk(4'hD, 1, 1, 4'hA);
      step();
      check("ill_flag", 32'({out_valid, illegal, mem_w, is_jump, out_en}), 32'b11000);
      idle();

      // same-cycle writeback and set of one index: set wins
      do_reset();
      wb_en = 1; wb_addr = 1; wb_data = 4'hC; in_valid = 1; inst = mk(4'h3, 1, 0, 4'd2);
      step();
      check("setwin_acc", 32'(last_ready), 32'd1);
      wb_en = 0; inst = mk(4'h5, 0, 1, 0);
      step();
      check("setwin_pend", 32'(last_ready), 32'd0);
      idle();
      do_reset();
      wb_en = 1; wb_addr = 1; wb_data = 4'hC; out_ready = 0; in_valid = 1;
      inst = mk(4'h3, 1, 0, 4'd2);
      step();
      wb_en = 0; in_valid = 0; flush = 1;
      step();
      flush = 0; in_valid = 1; inst = mk(4'h1, 0, 1, 0);
      step();
      check("setwin_reg", 32'(op_a), 32'hC);
      idle();

      // randomized traffic with an EX model that retires issued writes
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 99) != 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         inst      = IW'($urandom);
         flush     = ($urandom_range(0, 9) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         if (wbq.size() > 0 && $urandom_range(0, 2) == 0) begin
            w = wbq.pop_front();
            wb_en = 1; wb_addr = w.addr; wb_data = w.data;
         end else begin
            wb_en = 0; wb_addr = RW'($urandom); wb_data = DW'($urandom);
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
